// File: rtl/braille_pkg.sv
// Shared definitions for the braille entry buffer and the downstream
// 7-segment decoder stage.
package braille_pkg;

  localparam int CELL_W  = 6;
  localparam int DEPTH   = 4;
  localparam int COUNT_W = $clog2(DEPTH + 1);

  typedef logic [CELL_W-1:0]  cell_t;
  typedef logic [COUNT_W-1:0] count_t;

  // Occupancy after one more entry; a full buffer stays full.
  function automatic count_t count_inc(input count_t c);
    return (c == count_t'(DEPTH)) ? c : c + count_t'(1);
  endfunction

endpackage

// File: rtl/braille_entry_key_debounce.sv
// Per-key conditioning: two-flop synchronizer, stable-level debounce counter
// and a one-cycle press strobe on each accepted 1->0 level change.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press
);

  localparam int                CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic             r_level;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic [1:0]       r_fill;
  logic             r_armed;

  // r_armed stays low until the key is seen released after reset, so a key
  // held through reset cannot produce a press when its level finally drops.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
      r_fill  <= '0;
      r_armed <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop samples the
      // pre-edge value of its source and the synchronizer really is two stages.
      r_meta  <= i_key_n;
      r_sync  <= r_meta;
      r_fill  <= {r_fill[0], 1'b1};
      r_armed <= r_armed | (r_fill[1] & r_sync);
      r_press <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync;
        r_cnt   <= '0;
        r_press <= r_armed & ~r_sync;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/braille_entry.sv
// Four-cell braille entry buffer: debounced enter/clear keys, newest cell in
// CELL0, per-cell valid bits and a saturating occupancy count.
module braille_entry
  import braille_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic [CELL_W-1:0]  SW,
  input  logic               KEY_ENTER,
  input  logic               KEY_CLEAR,
  output logic [CELL_W-1:0]  CELL0,
  output logic [CELL_W-1:0]  CELL1,
  output logic [CELL_W-1:0]  CELL2,
  output logic [CELL_W-1:0]  CELL3,
  output logic [DEPTH-1:0]   VALID,
  output logic [COUNT_W-1:0] COUNT,
  output logic               ENTER_PULSE
);

  logic w_enter_evt;
  logic w_clear_evt;

  cell_t            r_sw_meta;
  cell_t            r_sw_sync;
  cell_t            r_cell [DEPTH];
  logic [DEPTH-1:0] r_valid;
  count_t           r_count;
  logic             r_enter_pulse;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_key (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET),
    .i_key_n (KEY_ENTER),
    .o_press (w_enter_evt)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_key (
    .i_clk   (CLOCK_50),
    .i_rst   (RESET),
    .i_key_n (KEY_CLEAR),
    .o_press (w_clear_evt)
  );

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_sw_meta <= '1;
      r_sw_sync <= '1;
    end else begin
      r_sw_meta <= SW;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Clear has priority over a simultaneous enter, which is simply dropped.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      // NOTE: the cell array is four small registers, not a RAM, so resetting
      // every entry is cheap and keeps the displays blank out of reset.
      for (int i = 0; i < DEPTH; i++) r_cell[i] <= '0;
      r_valid       <= '0;
      r_count       <= '0;
      r_enter_pulse <= 1'b0;
    end else begin
      r_enter_pulse <= 1'b0;
      if (w_clear_evt) begin
        for (int i = 0; i < DEPTH; i++) r_cell[i] <= '0;
        r_valid <= '0;
        r_count <= '0;
      end else if (w_enter_evt) begin
        r_cell[0] <= r_sw_sync;
        for (int i = 1; i < DEPTH; i++) r_cell[i] <= r_cell[i-1];
        r_valid       <= {r_valid[DEPTH-2:0], 1'b1};
        r_count       <= count_inc(r_count);
        r_enter_pulse <= 1'b1;
      end
    end
  end

  assign CELL0       = r_cell[0];
  assign CELL1       = r_cell[1];
  assign CELL2       = r_cell[2];
  assign CELL3       = r_cell[3];
  assign VALID       = r_valid;
  assign COUNT       = r_count;
  assign ENTER_PULSE = r_enter_pulse;

endmodule

// File: tb/tb_braille_entry.sv
// Self-checking bench for braille_entry with a short debounce window; expected
// buffer states are queued at each enter and compared when ENTER_PULSE fires.
module tb_braille_entry;

  localparam int D = 4;

  typedef struct packed {
    logic [23:0] cells;   // {CELL3, CELL2, CELL1, CELL0}
    logic [3:0]  valid;
    logic [2:0]  count;
  } snap_t;

  logic       clk = 1'b0;
  logic       RESET;
  logic [5:0] SW;
  logic       KEY_ENTER;
  logic       KEY_CLEAR;
  logic [5:0] CELL0, CELL1, CELL2, CELL3;
  logic [3:0] VALID;
  logic [2:0] COUNT;
  logic       ENTER_PULSE;

  snap_t sb_q[$];
  snap_t model;
  int    n_checks  = 0;
  int    n_pass    = 0;
  int    pulse_cnt = 0;

  braille_entry #(.DEBOUNCE_CYCLES(D)) dut (
    .CLOCK_50    (clk),
    .RESET       (RESET),
    .SW          (SW),
    .KEY_ENTER   (KEY_ENTER),
    .KEY_CLEAR   (KEY_CLEAR),
    .CELL0       (CELL0),
    .CELL1       (CELL1),
    .CELL2       (CELL2),
    .CELL3       (CELL3),
    .VALID       (VALID),
    .COUNT       (COUNT),
    .ENTER_PULSE (ENTER_PULSE)
  );

  always #5 clk = ~clk;

  // Counts the cycles in which ENTER_PULSE was high.
  always @(posedge clk) if (ENTER_PULSE === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  function automatic snap_t dut_snap();
    snap_t s;
    s.cells = {CELL3, CELL2, CELL1, CELL0};
    s.valid = VALID;
    s.count = COUNT;
    return s;
  endfunction

  function automatic snap_t model_enter(input snap_t s, input logic [5:0] sw);
    snap_t n;
    n.cells = {s.cells[17:0], sw};
    n.valid = {s.valid[2:0], 1'b1};
    n.count = (s.count == 3'd4) ? 3'd4 : s.count + 3'd1;
    return n;
  endfunction

  task automatic check_state(input string tag, input snap_t e);
    snap_t s;
    s = dut_snap();
    check({tag, "_cells"}, 32'(s.cells), 32'(e.cells));
    check({tag, "_valid"}, 32'(s.valid), 32'(e.valid));
    check({tag, "_count"}, 32'(s.count), 32'(e.count));
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press and hold enter, compare against the queued expectation when the
  // strobe appears, then release and confirm the hold gave a single pulse.
  task automatic press_enter(input logic [5:0] sw, input bit check_lat);
    snap_t e;
    int    lat;
    int    p0;
    SW    = sw;
    model = model_enter(model, sw);
    sb_q.push_back(model);
    p0        = pulse_cnt;
    KEY_ENTER = 1'b0;
    lat       = 0;
    while (ENTER_PULSE !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (ENTER_PULSE === 1'b1) begin
      e = sb_q.pop_front();
      check_state("enter", e);
      if (check_lat) check("enter_latency", 32'(lat), 32'd7);
    end else begin
      check("enter_pulse_timeout", 32'(lat), 32'd7);
    end
    wait_cycles(8);
    KEY_ENTER = 1'b1;
    wait_cycles(D + 6);
    check("enter_once", 32'(pulse_cnt - p0), 32'd1);
  endtask

  task automatic press_clear(input bit with_enter);
    int p0;
    p0        = pulse_cnt;
    KEY_CLEAR = 1'b0;
    if (with_enter) KEY_ENTER = 1'b0;
    wait_cycles(D + 8);
    model = '0;
    check_state(with_enter ? "clear_enter" : "clear", model);
    KEY_CLEAR = 1'b1;
    KEY_ENTER = 1'b1;
    wait_cycles(D + 6);
    check(with_enter ? "clear_enter_no_pulse" : "clear_no_pulse", 32'(pulse_cnt - p0), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    RESET     = 1'b1;
    SW        = '0;
    KEY_ENTER = 1'b1;
    KEY_CLEAR = 1'b1;
    model     = '0;
    wait_cycles(3);
    RESET = 1'b0;
    check_state("reset", '0);
    check("reset_pulse", 32'(ENTER_PULSE), 32'd0);
    wait_cycles(4);

    // Single enter: latency and first cell.
    press_enter(6'b000001, 1'b1);
    check("first_cell0", 32'(CELL0), 32'h01);
    check("first_valid", 32'(VALID), 32'h1);

    // Fill past capacity; the oldest cell falls out.
    press_enter(6'b000011, 1'b0);
    press_enter(6'b001001, 1'b0);
    press_enter(6'b011001, 1'b0);
    press_enter(6'b010001, 1'b0);
    check("full_cells", 32'({CELL3, CELL2, CELL1, CELL0}),
          32'({6'b000011, 6'b001001, 6'b011001, 6'b010001}));
    check("full_valid", 32'(VALID), 32'hf);
    check("full_count", 32'(COUNT), 32'd4);

    // Switch activity alone changes nothing.
    SW = 6'b111111;
    wait_cycles(20);
    check_state("sw_idle", model);

    // Bounces shorter than the debounce window.
    p0 = pulse_cnt;
    repeat (5) begin
      KEY_ENTER = 1'b0;
      wait_cycles(3);
      KEY_ENTER = 1'b1;
      wait_cycles(3);
    end
    wait_cycles(10);
    check("bounce_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    check_state("bounce", model);

    // Blank cell into a full buffer: stored as valid, count saturates.
    press_enter(6'b000000, 1'b0);
    check("blank_cell0", 32'(CELL0), 32'h00);
    check("sat_count", 32'(COUNT), 32'd4);
    check("sat_cell3", 32'(CELL3), 32'(6'b001001));

    press_clear(1'b0);

    // Clear wins over a simultaneous enter.
    press_enter(6'b100001, 1'b0);
    press_enter(6'b110000, 1'b0);
    press_enter(6'b000110, 1'b0);
    check("three_count", 32'(COUNT), 32'd3);
    press_clear(1'b1);

    // Reset in the middle of a held key's debounce.
    press_enter(6'b000111, 1'b0);
    p0        = pulse_cnt;
    KEY_ENTER = 1'b0;
    wait_cycles(4);
    RESET = 1'b1;
    wait_cycles(2);
    RESET = 1'b0;
    model = '0;
    wait_cycles(20);
    check_state("reset_held", model);
    check("reset_held_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    KEY_ENTER = 1'b1;
    wait_cycles(12);
    check("release_no_pulse", 32'(pulse_cnt - p0), 32'd0);
    press_enter(6'b101010, 1'b1);
    check("after_reset_count", 32'(COUNT), 32'd1);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/braille_entry.md
BRAILLE_ENTRY -- requirements
Module: braille_entry

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz): the number of consecutive stable cycles needed to accept a key level change; legal values are at least 2.
REQ-002 CLOCK_50  input  1  sole clock, rising edge.
REQ-003 RESET  input  1  reset: synchronous, active-high.
REQ-004 SW  input  6  braille dots 0..5 (bit n = dot n, 1 = raised); asynchronous to CLOCK_50.
REQ-005 KEY_ENTER  input  1  raw pushbutton, active-low; a press commits SW as a new cell.
REQ-006 KEY_CLEAR  input  1  raw pushbutton, active-low; a press empties the buffer.
REQ-007 CELL0..CELL3  output  6 each  buffered braille cells, newest in CELL0; feeds the per-digit 7-segment decoders.
REQ-008 VALID  output  4  bit n = CELLn holds an entered character.
REQ-009 COUNT  output  3  number of valid cells, 0..4.
REQ-010 ENTER_PULSE  output  1  one-cycle strobe in the cycle the buffer updates after an accepted enter.

Function
REQ-011 SW, KEY_ENTER and KEY_CLEAR SHALL each pass through a two-flop synchronizer before any use.
REQ-012 Each key SHALL keep a debounced level and a counter: sync level equal to debounced level -> counter cleared; unequal -> counter increments; unequal at counter = DEBOUNCE_CYCLES-1 -> debounced level takes the sync level and counter clears.
REQ-013 A 1->0 transition of a debounced level SHALL create a one-cycle press event on the following cycle; release (0->1) creates no event.
REQ-014 Latency from a stable raw key edge to its press event SHALL be 2 (sync) + DEBOUNCE_CYCLES + 1 cycles.
REQ-015 An enter event SHALL shift the buffer: CELL3<=CELL2, CELL2<=CELL1, CELL1<=CELL0, CELL0<=synchronized SW, with VALID shifting left and a 1 entering bit 0.
REQ-016 An enter with COUNT=4 SHALL discard the old CELL3, and COUNT SHALL saturate at 4.
REQ-017 An enter with SW=000000 SHALL store a valid blank cell.
REQ-018 ENTER_PULSE SHALL be high in the same cycle the CELLn registers take their new value, for exactly one cycle per press.
REQ-019 A clear event SHALL set all CELLn to 0, VALID to 0 and COUNT to 0 in one cycle, without asserting ENTER_PULSE.
REQ-020 If clear and enter events occur in the same cycle, clear SHALL win and the enter SHALL be dropped.
REQ-021 A held key SHALL produce exactly one event; bounces shorter than DEBOUNCE_CYCLES SHALL produce none.
REQ-022 SW changes that happen without an enter event SHALL have no effect on any output.

Reset
REQ-023 RESET high on a clock edge SHALL set: CELLn=0, VALID=0, COUNT=0, ENTER_PULSE=0, synchronizer flops=1, debounced levels=1 (released), debounce counters=0, event flags=0.
REQ-024 RESET SHALL override any event in the same cycle; a key held across reset deassertion SHALL produce no event until it is released and pressed again.

Structure
REQ-025 Package braille_pkg SHALL hold CELL_W=6, DEPTH=4 and the braille cell typedef, all shared with the 7-segment decoder stage.
REQ-026 Sub-module key_debounce (synchronizer, counter, debounced level, press event) SHALL be instantiated once per key; DEBOUNCE_CYCLES passes through to it.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 SW=000001, KEY_ENTER low and held -> ENTER_PULSE exactly once, 7 cycles after the edge; CELL0=000001, VALID=0001, COUNT=1.
REQ-028 Five enters with SW=000001,000011,001001,011001,010001 -> CELL3..CELL0=000011,001001,011001,010001; VALID=1111; COUNT=4.
REQ-029 KEY_ENTER low 3 cycles, then high, repeated 5 times -> no ENTER_PULSE; outputs unchanged.
REQ-030 With COUNT=3, KEY_ENTER and KEY_CLEAR falling on the same cycle -> all CELLn=0, VALID=0000, COUNT=0, no ENTER_PULSE.
REQ-031 RESET asserted 2 cycles into a debounce while KEY_ENTER is held -> all outputs 0 and no event; after release, one new press -> COUNT=1.
